// File: rtl/bus_pkg.sv
// Shared widths and state encoding for the bus initiator port.
package bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    ADDR  = 3'd2,
    ACK   = 3'd3,
    WDATA = 3'd4,
    RDATA = 3'd5,
    SPLIT = 3'd6,
    DONE  = 3'd7
  } init_state_t;

  // States in which the port holds a request towards the arbiter.
  function automatic logic owns_bus(init_state_t s);
    return s inside {REQ, ADDR, ACK, WDATA, RDATA};
  endfunction

endpackage

// File: rtl/init_serializer.sv
// Parallel-load, LSB-first serial shifter with a bit counter; shared by the
// address and write-data phases.
module init_serializer
  import bus_pkg::*;
#(
  parameter int W = ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         bit_out,
  output logic [4:0]   bit_cnt
);

  logic [W-1:0] sh;

  // The shifter drains to zero, so the serial line idles low between phases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sh      <= din;
      bit_cnt <= '0;
    end else if (shift) begin
      sh      <= sh >> 1;
      bit_cnt <= bit_cnt + 5'd1;
    end
  end

  assign bit_out = sh[0];

endmodule

// File: rtl/bus_init_port.sv
// Bus initiator: accepts one master transfer, arbitrates, serialises address
// and write data, collects serial read data, and handles split re-grants.
module bus_init_port
  import bus_pkg::*;
#(
  parameter int ACK_TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_req,
  input  logic              m_rw,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic              m_ready,
  output logic [DATA_W-1:0] m_rdata,
  output logic              m_rdata_valid,
  output logic              m_done,
  output logic              m_err,
  output logic              bus_req,
  input  logic              arbiter_grant,
  output logic              bus_data_out,
  output logic              bus_data_out_valid,
  output logic              bus_mode,
  output logic              bus_rw,
  input  logic              bus_data_in,
  input  logic              bus_data_in_valid,
  input  logic              bus_s_ack,
  input  logic              bus_split_ack,
  output logic [2:0]        dbg_state
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

  // Handshake: a master request is taken on any rising edge where m_req and
  // m_ready are both high; bus_data_out / bus_data_in are meaningful only in
  // cycles where their *_valid qualifier is high, with no back-pressure.
  init_state_t       state, state_nx;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [TO_W-1:0]   to_cnt;
  logic [4:0]        rd_cnt;
  logic [DATA_W-1:0] rd_sh;

  logic              accept;
  logic              to_hit;
  logic              to_inc;
  logic              rd_take;
  logic              rd_last;
  logic              abort;
  logic              ser_load;
  logic              ser_shift;
  logic [ADDR_W-1:0] ser_din;
  logic [4:0]        ser_cnt;
  logic              ser_bit;

  assign accept    = m_req && m_ready;
  assign to_hit    = (to_cnt == TO_W'(ACK_TIMEOUT - 1));
  assign dbg_state = state;

  init_serializer #(.W(ADDR_W)) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (ser_load),
    .shift   (ser_shift),
    .din     (ser_din),
    .bit_out (ser_bit),
    .bit_cnt (ser_cnt)
  );

  assign bus_data_out = ser_bit;

  always_comb begin
    state_nx  = state;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    ser_din   = '0;
    to_inc    = 1'b0;
    rd_take   = 1'b0;
    rd_last   = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: if (accept) state_nx = REQ;
      REQ: begin
        if (arbiter_grant) begin
          state_nx = ADDR;
          ser_load = 1'b1;
          ser_din  = addr_q;
        end
      end
      ADDR: begin
        ser_shift = 1'b1;
        if (ser_cnt == 5'(ADDR_W - 1)) state_nx = ACK;
      end
      ACK: begin
        // A split answer outranks a simultaneous accept, but only for reads.
        if (bus_split_ack && !rw_q) begin
          state_nx = SPLIT;
        end else if (bus_s_ack) begin
          if (rw_q) begin
            state_nx = WDATA;
            ser_load = 1'b1;
            ser_din  = ADDR_W'(wdata_q);
          end else begin
            state_nx = RDATA;
          end
        end else if (to_hit) begin
          state_nx = DONE;
          abort    = 1'b1;
        end else begin
          to_inc = 1'b1;
        end
      end
      WDATA: begin
        ser_shift = 1'b1;
        if (ser_cnt == 5'(DATA_W - 1)) state_nx = DONE;
      end
      RDATA: begin
        if (bus_data_in_valid) begin
          rd_take = 1'b1;
          if (rd_cnt == 5'(DATA_W - 1)) begin
            rd_last  = 1'b1;
            state_nx = DONE;
          end
        end else if (to_hit) begin
          state_nx = DONE;
          abort    = 1'b1;
        end else begin
          to_inc = 1'b1;
        end
      end
      SPLIT: if (arbiter_grant) state_nx = RDATA;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      rw_q               <= 1'b0;
      addr_q             <= '0;
      wdata_q            <= '0;
      to_cnt             <= '0;
      rd_cnt             <= '0;
      rd_sh              <= '0;
      m_ready            <= 1'b0;
      m_rdata            <= '0;
      m_rdata_valid      <= 1'b0;
      m_done             <= 1'b0;
      m_err              <= 1'b0;
      bus_req            <= 1'b0;
      bus_data_out_valid <= 1'b0;
      bus_mode           <= 1'b0;
      bus_rw             <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        rw_q    <= m_rw;
        addr_q  <= m_addr;
        wdata_q <= m_wdata;
        rd_cnt  <= '0;
      end else if (rd_take) begin
        rd_cnt <= rd_cnt + 5'd1;
      end
      // Timeout restarts on every state change and every received read bit;
      // in SPLIT nothing increments it, so it simply holds.
      if ((state_nx != state) || rd_take) begin
        to_cnt <= '0;
      end else if (to_inc) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      if (rd_take) rd_sh[rd_cnt[2:0]] <= bus_data_in;
      if (rd_last) m_rdata <= {bus_data_in, rd_sh[DATA_W-2:0]};
      // Outputs are decoded from the next state so they line up with it.
      m_ready            <= (state_nx == IDLE);
      m_done             <= (state_nx == DONE);
      m_err              <= abort;
      m_rdata_valid      <= rd_last;
      bus_req            <= owns_bus(state_nx);
      bus_data_out_valid <= (state_nx inside {ADDR, WDATA});
      bus_mode           <= (state_nx inside {WDATA, RDATA});
      bus_rw             <= (state_nx inside {ADDR, ACK, WDATA, RDATA, SPLIT, DONE})
                            ? rw_q : 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_init_port.sv
// Directed bench for bus_init_port: each transfer is described phase by phase,
// expanded into a per-cycle stimulus/expectation plan and checked every cycle.
module tb_bus_init_port;

  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_req = 1'b0;
  logic        m_rw = 1'b0;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_wdata = '0;
  logic        m_ready;
  logic [7:0]  m_rdata;
  logic        m_rdata_valid;
  logic        m_done;
  logic        m_err;
  logic        bus_req;
  logic        arbiter_grant = 1'b0;
  logic        bus_data_out;
  logic        bus_data_out_valid;
  logic        bus_mode;
  logic        bus_rw;
  logic        bus_data_in = 1'b0;
  logic        bus_data_in_valid = 1'b0;
  logic        bus_s_ack = 1'b0;
  logic        bus_split_ack = 1'b0;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  bus_init_port #(.ACK_TIMEOUT(TO)) dut (
    .clk                (clk),
    .rst                (rst),
    .m_req              (m_req),
    .m_rw               (m_rw),
    .m_addr             (m_addr),
    .m_wdata            (m_wdata),
    .m_ready            (m_ready),
    .m_rdata            (m_rdata),
    .m_rdata_valid      (m_rdata_valid),
    .m_done             (m_done),
    .m_err              (m_err),
    .bus_req            (bus_req),
    .arbiter_grant      (arbiter_grant),
    .bus_data_out       (bus_data_out),
    .bus_data_out_valid (bus_data_out_valid),
    .bus_mode           (bus_mode),
    .bus_rw             (bus_rw),
    .bus_data_in        (bus_data_in),
    .bus_data_in_valid  (bus_data_in_valid),
    .bus_s_ack          (bus_s_ack),
    .bus_split_ack      (bus_split_ack),
    .dbg_state          (dbg_state)
  );

  // Output vector: {ready, done, err, rdata_valid, req, dout_valid, dout, mode, rw}
  typedef struct packed {
    logic       m_req;
    logic       grant;
    logic       s_ack;
    logic       split;
    logic       din;
    logic       din_v;
    logic [8:0] e;
    logic [8:0] m;
    logic [7:0] rd;
  } plan_t;

  plan_t       plan_q[$];
  logic [8:0]  exp_q[$];
  logic [8:0]  msk_q[$];
  logic [7:0]  rd_q[$];
  int          total = 0;
  int          bad = 0;

  logic        cur_rw;
  logic [15:0] cur_addr;
  logic [7:0]  cur_wd;

  logic [15:0] obs_addr;
  logic [7:0]  obs_wd;
  logic [7:0]  obs_rd;
  int          done_seen;
  int          err_seen;
  int          rv_done_seen;

  function automatic logic [8:0] ov(logic ready, logic done, logic err, logic rv,
                                    logic req, logic dov, logic dout, logic mode,
                                    logic rw);
    return {ready, done, err, rv, req, dov, dout, mode, rw};
  endfunction

  function automatic logic [8:0] mk(logic c_dout, logic c_mode, logic c_rw);
    return {6'h3F, c_dout, c_mode, c_rw};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic add(input logic mreq, input logic grant, input logic sack,
                     input logic split, input logic din, input logic dinv,
                     input logic [8:0] e, input logic [8:0] m, input logic [7:0] rd);
    plan_t p;
    p.m_req = mreq; p.grant = grant; p.s_ack = sack; p.split = split;
    p.din = din; p.din_v = dinv; p.e = e; p.m = m; p.rd = rd;
    plan_q.push_back(p);
  endtask

  // ---- phase builders: expected outputs straight from the port's behaviour
  task automatic ph_idle(input logic mreq);
    add(mreq, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), mk(1'b0, 1'b0, 1'b0), 8'h00);
  endtask

  task automatic ph_req(input int wait_n);
    for (int i = 0; i <= wait_n; i++)
      add(1'b0, (i == wait_n), 1'b0, 1'b0, 1'b0, 1'b0,
          ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), mk(1'b0, 1'b0, 1'b0), 8'h00);
  endtask

  task automatic ph_addr(input int nbits);
    for (int i = 0; i < nbits; i++)
      add((i inside {3, 4}), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
          ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, cur_addr[i], 1'b0, cur_rw), mk(1'b1, 1'b1, 1'b1), 8'h00);
  endtask

  task automatic ph_ack(input int wait_n, input logic sack_last, input logic split_last,
                        input logic noise);
    for (int i = 0; i <= wait_n; i++) begin
      logic lst;
      lst = (i == wait_n);
      add(1'b0, 1'b0, lst && sack_last, (lst && split_last) || (noise && (i % 5 == 1)),
          1'b1, noise && (i % 7 == 2),
          ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, cur_rw), mk(1'b0, 1'b0, 1'b1), 8'h00);
    end
  endtask

  task automatic ph_wdata();
    for (int j = 0; j < 8; j++)
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
          ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, cur_wd[j], 1'b1, 1'b1), mk(1'b1, 1'b1, 1'b1), 8'h00);
  endtask

  task automatic ph_split(input int n);
    for (int i = 0; i <= n; i++)
      add(1'b0, (i == n), 1'b0, 1'b0, 1'b1, (i == 2 || i == 5),
          ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), mk(1'b0, 1'b0, 1'b1), 8'h00);
  endtask

  task automatic ph_rdata(input logic [7:0] val, input logic gappy);
    for (int k = 0; k < 8; k++) begin
      int gap;
      gap = gappy ? (k % 3) : 0;
      for (int g = 0; g < gap; g++)
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
            ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), mk(1'b0, 1'b0, 1'b1), 8'h00);
      add(1'b0, 1'b0, 1'b0, 1'b0, val[k], 1'b1,
          ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), mk(1'b0, 1'b0, 1'b1), 8'h00);
    end
  endtask

  task automatic ph_done(input logic err, input logic [7:0] rd);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        ov(1'b0, 1'b1, err, !cur_rw && !err, 1'b0, 1'b0, 1'b0, 1'b0, cur_rw),
        mk(1'b0, 1'b0, 1'b1), rd);
  endtask

  // ---- driver: one plan entry per cycle, expectation handed to the scoreboard
  task automatic run();
    while (plan_q.size() > 0) begin
      plan_t p;
      @(posedge clk);
      #1;
      p = plan_q.pop_front();
      m_req             = p.m_req;
      m_rw              = cur_rw;
      m_addr            = cur_addr;
      m_wdata           = cur_wd;
      arbiter_grant     = p.grant;
      bus_s_ack         = p.s_ack;
      bus_split_ack     = p.split;
      bus_data_in       = p.din;
      bus_data_in_valid = p.din_v;
      exp_q.push_back(p.e);
      msk_q.push_back(p.m);
      if (p.e[5]) rd_q.push_back(p.rd);
    end
  endtask

  task automatic clear_obs();
    done_seen = 0; err_seen = 0; rv_done_seen = 0;
    obs_addr = '0; obs_wd = '0; obs_rd = '0;
  endtask

  // ---- scoreboard / observer
  always @(negedge clk) begin
    logic [8:0] a, e, m;
    logic [7:0] r;
    a = {m_ready, m_done, m_err, m_rdata_valid, bus_req, bus_data_out_valid,
         bus_data_out, bus_mode, bus_rw};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      total++;
      if ((a & m) !== (e & m)) begin
        bad++;
        $display("FAIL out_vec t=%0t actual=%b required=%b care=%b", $time, a, e, m);
      end
      if (e[5] && rd_q.size() > 0) begin
        r = rd_q.pop_front();
        total++;
        if (m_rdata !== r) begin
          bad++;
          $display("FAIL m_rdata t=%0t actual=%h required=%h", $time, m_rdata, r);
        end
      end
    end
    if (bus_data_out_valid && !bus_mode) obs_addr = {bus_data_out, obs_addr[15:1]};
    if (bus_data_out_valid && bus_mode)  obs_wd   = {bus_data_out, obs_wd[7:1]};
    if (m_rdata_valid) obs_rd = m_rdata;
    if (m_done) done_seen++;
    if (m_err) err_seen++;
    if (m_rdata_valid && m_done) rv_done_seen++;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    clear_obs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {15'd0, m_ready, m_done, m_err, m_rdata_valid, bus_req,
          bus_data_out_valid, bus_data_out, bus_mode, bus_rw, m_rdata}, 32'd0);
    #1 rst = 1'b0;
    #1 check("ready_before_first_edge", {31'd0, m_ready}, 32'd0);

    // write 0xA5 to 0x1234, grant after 2 cycles, ack after 3
    cur_rw = 1'b1; cur_addr = 16'h1234; cur_wd = 8'hA5;
    ph_idle(1'b1); ph_req(2); ph_addr(16); ph_ack(3, 1'b1, 1'b0, 1'b0);
    ph_wdata(); ph_done(1'b0, 8'h00); ph_idle(1'b0);
    run();
    @(negedge clk); #1;
    check("wr_addr_word", {16'd0, obs_addr}, 32'h1234);
    check("wr_data_word", {24'd0, obs_wd}, 32'hA5);
    check("wr_done_count", done_seen, 1);
    check("wr_err_count", err_seen, 0);
    clear_obs();

    // read 0x00F0, target returns 0x3C with gaps
    cur_rw = 1'b0; cur_addr = 16'h00F0; cur_wd = 8'h00;
    ph_idle(1'b1); ph_req(0); ph_addr(16); ph_ack(1, 1'b1, 1'b0, 1'b0);
    ph_rdata(8'h3C, 1'b1); ph_done(1'b0, 8'h3C); ph_idle(1'b0);
    run();
    @(negedge clk); #1;
    check("rd_value", {24'd0, obs_rd}, 32'h3C);
    check("rd_valid_with_done", rv_done_seen, 1);
    clear_obs();

    // read with split and accept together, re-grant after 10 cycles
    cur_rw = 1'b0; cur_addr = 16'h0BEE; cur_wd = 8'h00;
    ph_idle(1'b1); ph_req(1); ph_addr(16); ph_ack(0, 1'b1, 1'b1, 1'b0);
    ph_split(10); ph_rdata(8'h81, 1'b0); ph_done(1'b0, 8'h81); ph_idle(1'b0);
    run();
    @(negedge clk); #1;
    check("split_rd_value", {24'd0, obs_rd}, 32'h81);
    check("split_done_count", done_seen, 1);
    clear_obs();

    // write never acknowledged: timeout abort, split noise ignored
    cur_rw = 1'b1; cur_addr = 16'h5555; cur_wd = 8'h3C;
    ph_idle(1'b1); ph_req(0); ph_addr(16); ph_ack(TO - 1, 1'b0, 1'b0, 1'b1);
    ph_done(1'b1, 8'h00); ph_idle(1'b0);
    run();
    @(negedge clk); #1;
    check("to_err_count", err_seen, 1);
    check("to_done_count", done_seen, 1);
    check("to_no_wdata", {24'd0, obs_wd}, 32'h00);
    clear_obs();

    // reset at address bit 7, then a normal write
    cur_rw = 1'b1; cur_addr = 16'hC3A1; cur_wd = 8'h55;
    ph_idle(1'b1); ph_req(1); ph_addr(8);
    run();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_bus_req_immediate", {31'd0, bus_req}, 32'd0);
    check("rst_ready_low", {31'd0, m_ready}, 32'd0);
    check("rst_dout_valid_low", {31'd0, bus_data_out_valid}, 32'd0);
    @(negedge clk);
    check("rst_no_done", {30'd0, m_done, bus_req}, 32'd0);
    #1 rst = 1'b0;
    check("rst_done_count", done_seen, 0);
    clear_obs();
    cur_rw = 1'b1; cur_addr = 16'h8001; cur_wd = 8'h7E;
    ph_idle(1'b1); ph_req(0); ph_addr(16); ph_ack(0, 1'b1, 1'b0, 1'b0);
    ph_wdata(); ph_done(1'b0, 8'h00); ph_idle(1'b0);
    run();
    @(negedge clk); #1;
    check("post_rst_addr", {16'd0, obs_addr}, 32'h8001);
    check("post_rst_data", {24'd0, obs_wd}, 32'h7E);
    check("post_rst_done", done_seen, 1);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_init_port.md
BUS_INIT_PORT -- requirements
Module: bus_init_port

Interface
REQ-001 Parameter SHALL be: ACK_TIMEOUT, 32, max cycles waiting for target ack or next read bit before abort.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 m_req  in  1  master requests a transfer.
REQ-005 m_rw  in  1  1 write, 0 read.
REQ-006 m_addr  in  16  target address.
REQ-007 m_wdata  in  8  write data.
REQ-008 m_ready  out  1  port idle, request accepted when m_req&&m_ready.
REQ-009 m_rdata  out  8  read data.
REQ-010 m_rdata_valid  out  1  one-cycle pulse, m_rdata valid.
REQ-011 m_done  out  1  one-cycle pulse, transfer finished.
REQ-012 m_err  out  1  one-cycle pulse with m_done on timeout abort.
REQ-013 bus_req  out  1  request to arbiter.
REQ-014 arbiter_grant  in  1  grant / split re-grant from arbiter.
REQ-015 bus_data_out  out  1  serial bit to target.
REQ-016 bus_data_out_valid  out  1  bus_data_out qualifier.
REQ-017 bus_mode  out  1  1 data phase, 0 address phase.
REQ-018 bus_rw  out  1  latched m_rw, held from ADDR through DONE.
REQ-019 bus_data_in  in  1  serial read bit from target.
REQ-020 bus_data_in_valid  in  1  bus_data_in qualifier.
REQ-021 bus_s_ack  in  1  target accepted address.
REQ-022 bus_split_ack  in  1  target splits the read.

Function
REQ-023 FSM states SHALL be IDLE, REQ, ADDR, ACK, WDATA, RDATA, SPLIT, DONE; all outputs registered.
REQ-024 IDLE: m_ready=1; on accept latch m_rw/m_addr/m_wdata, go REQ; m_req while busy ignored.
REQ-025 REQ: bus_req=1; arbiter_grant sampled high -> ADDR; first address bit driven the cycle after that edge.
REQ-026 ADDR: 16 consecutive cycles, bit i=0..15 (LSB first), bus_data_out_valid=1, bus_mode=0; then ACK. Grant drop during ADDR/WDATA ignored.
REQ-027 ACK: bus_s_ack -> WDATA (write) or RDATA (read); bus_split_ack on read -> SPLIT, has priority over simultaneous bus_s_ack; bus_split_ack on write ignored.
REQ-028 WDATA: 8 cycles, m_wdata LSB first, bus_mode=1, valid=1; then DONE.
REQ-029 RDATA: bit k (k=0..7) captured from bus_data_in on each bus_data_in_valid; after 8th bit m_rdata updated -> DONE; bus_data_in_valid outside RDATA ignored.
REQ-030 SPLIT: bus_req=0, bit count and timeout frozen, no timeout; arbiter_grant high -> RDATA with bus_req=1.
REQ-031 DONE: one cycle, m_done=1, m_rdata_valid=1 for reads, bus_req=0; -> IDLE.
REQ-032 Timeout counter SHALL clear on state entry and on each received read bit; reaching ACK_TIMEOUT in ACK or RDATA -> DONE with m_err=1, m_rdata_valid=0.
REQ-033 bus_req SHALL be 1 from REQ through RDATA except SPLIT; bus_data_out_valid=0 outside ADDR/WDATA.
REQ-034 Bit counter 5 bits; timeout counter width clog2(ACK_TIMEOUT+1), no wrap.

Reset
REQ-035 rst high SHALL immediately force IDLE, all outputs 0 (incl. bus_req, m_ready), counters/latches 0; mid-transfer aborts without m_done.
REQ-036 m_ready SHALL rise at the first clock edge after rst deasserts.

Structure
REQ-037 Package bus_pkg SHALL hold ADDR_W=16, DATA_W=8 and enum init_state_t.
REQ-038 One sub-module init_serializer (parallel-load LSB-first shifter with bit counter) SHALL serve ADDR and WDATA.

Verification
REQ-039 Write 0xA5 to 0x1234, grant after 2 cycles, s_ack after 3 -> 16 addr bits 0x1234 LSB first mode=0, 8 bits 0xA5 mode=1, m_done, m_err=0.
REQ-040 Read 0x00F0, s_ack, target sends 0x3C with gaps -> m_rdata=0x3C, m_rdata_valid and m_done same cycle.
REQ-041 Read, split_ack and s_ack same cycle -> bus_req drops; re-grant after 10 cycles, bits 0x81 -> m_rdata=0x81.
REQ-042 Write, no ack for 32 cycles -> m_done=m_err=1, IDLE, m_ready=1 next cycle.
REQ-043 rst asserted at address bit 7 -> bus_req=0 immediately, no m_done; next request completes normally.
